jt12_slotreg: RTL and testbench
===============================

# jt12_slotreg

Parametrised operator-slot sequencer and per-slot register ring for the JT12 family. It generalises the fixed 3/6-channel, 4-operator slot counter to NUM_CH channels and NUM_OP operators. It adds a write-request handshake: a CPU-side register write is latched, held pending until its target slot reaches the ring head, then merged under a bit mask. It sits between the register-write decoder and the PG/EG/OP pipelines, and supplies slot position and per-slot parameters.

## Interface
Parameters:
- NUM_CH, 6, channel count, 1..8. For NUM_CH==6 channel ids are {0,1,2,4,5,6} (YM2612 map); otherwise ids are 0..NUM_CH-1.
- NUM_OP, 4, operators per channel, 1..4.
- RW, 8, register bits per slot.
- RSTVAL, 0, reset value of every ring bit, RW bits wide.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- clk_en  in  1  slot-advance enable
- wr  in  1  write request, sampled every clk
- wr_ch  in  3  target channel id
- wr_op  in  2  target operator
- wr_din  in  RW  write data
- wr_mask  in  RW  1 = bit is written
- busy  out  1  write pending
- wr_done  out  1  one-clk pulse when a write is applied
- err  out  1  sticky: dropped or invalid request
- cur_ch  out  3  channel id at ring head
- cur_op  out  2  operator at ring head
- zero  out  1  head is slot (op0, first ch)
- last  out  1  head is slot (op NUM_OP-1, last ch)
- slot_dout  out  RW  register contents of head slot

## Operation
- NUM_SLOTS = NUM_CH*NUM_OP. Order is op-major: for op 0..NUM_OP-1, each channel id ascending; wraps to (0, first id).
- Each clk_en edge advances cur_* one slot and rotates the ring by one stage. The new tail takes the old head, modified when a merge applies. slot_dout always equals the head stage.
- Write acceptance happens on a clk edge with wr=1, busy=0, rst=0. A valid request latches {wr_op, wr_ch, wr_din, wr_mask} and sets busy.
- Invalid target: wr_op>=NUM_OP, or a channel id outside the map (e.g. 3 when NUM_CH==6, or >=NUM_CH otherwise). The request is ignored and err is set; busy stays 0.
- wr=1 while busy=1: the request is dropped, err is set, and the pending write is unaffected.
- Merge happens on a clk_en edge with busy=1 and head == pending target. The recirculated value is (head & ~mask) | (din & mask). busy clears and wr_done pulses high for the following clk cycle.
- A write accepted on an edge merges at the first later clk_en edge where the head matches. It never merges on the acceptance edge itself.
- err clears only on rst.

## Timing
- Reset values: cur_op=0, cur_ch=0, zero=1, last=(NUM_SLOTS==1), busy=0, wr_done=0, err=0. All ring stages are RSTVAL, so slot_dout=RSTVAL.
- rst during a pending write drops the write and restores all reset values. No merge occurs on the rst edge.
- With clk_en held high, merge latency after acceptance is 1..NUM_SLOTS edges, and the busy width equals that latency.
- clk_en=0 freezes cur_*, ring, zero and last. Acceptance and err updates still occur.
- A merged value appears on slot_dout when its slot next reaches the head, NUM_SLOTS clk_en edges after the merge.
- zero and last are registered with cur_* and change on the same edge.
- wr on the same edge as a merge (busy=1) is dropped and sets err. A new write is accepted only from the cycle in which busy reads 0.

## Test plan
- Reset sequencing, NUM_CH=6, NUM_OP=4, clk_en=1: cur_ch steps 0,1,2,4,5,6 and cur_op 0..3. zero pulses every 24 edges, last precedes zero by one edge, and slot_dout=RSTVAL throughout.
- Write op2/ch5, din=0xA5, mask=0xFF, accepted while zero=1: busy is high for 16 cycles and wr_done pulses once. slot_dout=0xA5 when cur=(2,5) on the next rotation. All other slots read 0x00.
- Masked write: slot (1,0) preset to 0xF0, then a write with din=0x0F, mask=0x3C gives slot_dout=0xCC on its next visit.
- Write wr_ch=3 with NUM_CH=6, or wr_op=3 with NUM_OP=2: err=1, busy stays 0, and no slot changes. A second wr during busy: err=1 and the original write completes unchanged.
- NUM_CH=3, NUM_OP=2, clk_en toggling every other clk: sequence has 6 slots and wrap-around is correct. With a write pending, cur_* and busy hold while clk_en=0.
- rst asserted mid-pending (busy=1): the next cycle shows busy=0, err=0, cur=(0,0), and the target slot is still RSTVAL after a full rotation.

Source files
------------

// File: rtl/jt12_slotreg_if.sv
// CPU-side register write handshake for the JT12 slot register ring.
// The master issues requests; the slave reports pending, completion and errors.
interface jt12_slotreg_if #(
  parameter int RW = 8
);
  logic          wr;
  logic [2:0]    wr_ch;
  logic [1:0]    wr_op;
  logic [RW-1:0] wr_din;
  logic [RW-1:0] wr_mask;
  logic          busy;
  logic          wr_done;
  logic          err;

  modport master (
    output wr, wr_ch, wr_op, wr_din, wr_mask,
    input  busy, wr_done, err
  );

  modport slave (
    input  wr, wr_ch, wr_op, wr_din, wr_mask,
    output busy, wr_done, err
  );
endinterface

// File: rtl/jt12_slotreg.sv
// Operator-slot sequencer and per-slot register ring with a pending
// masked write that merges when its slot passes the ring head.
module jt12_slotreg #(
  parameter int            NUM_CH = 6,
  parameter int            NUM_OP = 4,
  parameter int            RW     = 8,
  parameter logic [RW-1:0] RSTVAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  jt12_slotreg_if.slave bus,
  output logic [2:0]    cur_ch,
  output logic [1:0]    cur_op,
  output logic          zero,
  output logic          last,
  output logic [RW-1:0] slot_dout
);

  localparam int NS = NUM_CH * NUM_OP;

  typedef enum logic {
    IDLE,
    PEND
  } st_t;

  st_t           st;
  st_t           st_n;
  logic [2:0]    chi;
  logic [1:0]    op;
  logic [RW-1:0] ring [NS];
  logic [2:0]    p_ch;
  logic [1:0]    p_op;
  logic [RW-1:0] p_din;
  logic [RW-1:0] p_mask;
  logic          ch_ok;
  logic          op_ok;
  logic          accept;
  logic          merge;
  logic          bad;
  logic          drop;
  logic          chi_end;
  logic          op_end;
  logic [RW-1:0] tail;

  // YM2612 channel map skips id 3 between the two banks
  assign cur_ch = (NUM_CH == 6 && chi >= 3'd3) ? chi + 3'd1 : chi;
  assign cur_op = op;

  assign chi_end = (chi == 3'(NUM_CH - 1));
  assign op_end  = (op == 2'(NUM_OP - 1));
  assign zero    = (chi == 3'd0) && (op == 2'd0);
  assign last    = chi_end && op_end;

  assign slot_dout = ring[0];
  assign bus.busy  = (st == PEND);

  assign ch_ok = (NUM_CH == 6) ?
                 (bus.wr_ch != 3'd3 && bus.wr_ch != 3'd7) :
                 ({1'b0, bus.wr_ch} < 4'(NUM_CH));
  assign op_ok = ({1'b0, bus.wr_op} < 3'(NUM_OP));

  always_comb begin
    st_n   = st;
    accept = 1'b0;
    merge  = 1'b0;
    bad    = 1'b0;
    drop   = 1'b0;
    unique case (st)
      IDLE: begin
        if (bus.wr) begin
          if (ch_ok && op_ok) begin
            accept = 1'b1;
            st_n   = PEND;
          end else begin
            bad = 1'b1;
          end
        end
      end
      PEND: begin
        drop = bus.wr;
        if (clk_en && cur_ch == p_ch && cur_op == p_op) begin
          merge = 1'b1;
          st_n  = IDLE;
        end
      end
      default: st_n = IDLE;
    endcase
    tail = merge ? ((ring[0] & ~p_mask) | (p_din & p_mask)) : ring[0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= IDLE;
      chi         <= 3'd0;
      op          <= 2'd0;
      p_ch        <= 3'd0;
      p_op        <= 2'd0;
      p_din       <= '0;
      p_mask      <= '0;
      bus.wr_done <= 1'b0;
      bus.err     <= 1'b0;
    end else begin
      st          <= st_n;
      bus.wr_done <= merge;
      if (bad || drop) bus.err <= 1'b1;
      if (accept) begin
        p_ch   <= bus.wr_ch;
        p_op   <= bus.wr_op;
        p_din  <= bus.wr_din;
        p_mask <= bus.wr_mask;
      end
      if (clk_en) begin
        if (chi_end) begin
          chi <= 3'd0;
          op  <= op_end ? 2'd0 : op + 2'd1;
        end else begin
          chi <= chi + 3'd1;
        end
      end
    end
  end

  // Head leaves at stage 0 and re-enters at the tail, possibly merged
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NS; i++) ring[i] <= RSTVAL;
    end else if (clk_en) begin
      for (int i = 0; i < NS - 1; i++) ring[i] <= ring[i+1];
      ring[NS-1] <= tail;
    end
  end

endmodule

// File: tb/tb_jt12_slotreg.sv
// Scoreboard bench for jt12_slotreg: a 6ch/4op and a 3ch/2op instance
// checked every cycle against a slot-table model plus directed values.
module tb_jt12_slotreg;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  jt12_slotreg_if #(.RW(8)) ba ();
  jt12_slotreg_if #(.RW(8)) bb ();

  logic       ena, enb;
  logic [2:0] cha, chb;
  logic [1:0] opa, opb;
  logic       za, zb, la, lb;
  logic [7:0] da, db;

  jt12_slotreg #(
    .NUM_CH(6), .NUM_OP(4), .RW(8), .RSTVAL(8'h00)
  ) ua (
    .clk(clk), .rst(rst), .clk_en(ena), .bus(ba),
    .cur_ch(cha), .cur_op(opa), .zero(za), .last(la), .slot_dout(da)
  );

  jt12_slotreg #(
    .NUM_CH(3), .NUM_OP(2), .RW(8), .RSTVAL(8'h00)
  ) ub (
    .clk(clk), .rst(rst), .clk_en(enb), .bus(bb),
    .cur_ch(chb), .cur_op(opb), .zero(zb), .last(lb), .slot_dout(db)
  );

  typedef struct {
    logic [2:0] ch;
    logic [1:0] op;
    logic       z;
    logic       l;
    logic [7:0] d;
    logic       busy;
    logic       done;
    logic       err;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  int         ids [2][8];
  int         nch [2];
  int         nop [2];
  int         m_idx [2];
  int         m_tgt [2];
  bit         m_busy [2];
  bit         m_err [2];
  bit         m_done [2];
  logic [7:0] m_din [2];
  logic [7:0] m_mask [2];
  logic [7:0] mm [2][32];

  bit         s_en [2];
  bit         s_wr [2];
  int         s_ch [2];
  int         s_op [2];
  logic [7:0] s_din [2];
  logic [7:0] s_mask [2];

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_e(string p, exp_t e, logic [2:0] ch, logic [1:0] op,
                       logic z, logic l, logic [7:0] d,
                       logic b, logic dn, logic er);
    chk({p, ".cur_ch"}, 32'(ch), 32'(e.ch));
    chk({p, ".cur_op"}, 32'(op), 32'(e.op));
    chk({p, ".zero"}, 32'(z), 32'(e.z));
    chk({p, ".last"}, 32'(l), 32'(e.l));
    chk({p, ".slot_dout"}, 32'(d), 32'(e.d));
    chk({p, ".busy"}, 32'(b), 32'(e.busy));
    chk({p, ".wr_done"}, 32'(dn), 32'(e.done));
    chk({p, ".err"}, 32'(er), 32'(e.err));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      chk_e("a", e, cha, opa, za, la, da, ba.busy, ba.wr_done, ba.err);
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      chk_e("b", e, chb, opb, zb, lb, db, bb.busy, bb.wr_done, bb.err);
    end
  end

  function automatic int chi_of(int k, int ch);
    for (int i = 0; i < nch[k]; i++)
      if (ids[k][i] == ch) return i;
    return -1;
  endfunction

  // Models one clk edge for instance k and queues the state it should show
  task automatic step(int k, bit r);
    exp_t e;
    int   ci;
    int   ns;
    bit   mg;
    ns = nch[k] * nop[k];
    if (r) begin
      m_idx[k]  = 0;
      m_busy[k] = 0;
      m_err[k]  = 0;
      m_done[k] = 0;
      for (int i = 0; i < 32; i++) mm[k][i] = 8'h00;
    end else begin
      mg = s_en[k] && m_busy[k] && (m_idx[k] == m_tgt[k]);
      m_done[k] = mg;
      if (s_wr[k]) begin
        ci = chi_of(k, s_ch[k]);
        if (m_busy[k] || ci < 0 || s_op[k] >= nop[k]) begin
          m_err[k] = 1;
        end else begin
          m_busy[k] = 1;
          m_tgt[k]  = s_op[k] * nch[k] + ci;
          m_din[k]  = s_din[k];
          m_mask[k] = s_mask[k];
        end
      end
      if (mg) begin
        mm[k][m_tgt[k]] = (mm[k][m_tgt[k]] & ~m_mask[k]) |
                          (m_din[k] & m_mask[k]);
        m_busy[k] = 0;
      end
      if (s_en[k]) m_idx[k] = (m_idx[k] + 1) % ns;
    end
    e.ch   = 3'(ids[k][m_idx[k] % nch[k]]);
    e.op   = 2'(m_idx[k] / nch[k]);
    e.z    = (m_idx[k] == 0);
    e.l    = (m_idx[k] == ns - 1);
    e.d    = mm[k][m_idx[k]];
    e.busy = m_busy[k];
    e.done = m_done[k];
    e.err  = m_err[k];
    if (k == 0) qa.push_back(e);
    else qb.push_back(e);
  endtask

  task automatic tick();
    ena        = s_en[0];
    ba.wr      = s_wr[0];
    ba.wr_ch   = 3'(s_ch[0]);
    ba.wr_op   = 2'(s_op[0]);
    ba.wr_din  = s_din[0];
    ba.wr_mask = s_mask[0];
    enb        = s_en[1];
    bb.wr      = s_wr[1];
    bb.wr_ch   = 3'(s_ch[1]);
    bb.wr_op   = 2'(s_op[1]);
    bb.wr_din  = s_din[1];
    bb.wr_mask = s_mask[1];
    step(0, rst);
    step(1, rst);
    @(posedge clk);
    #1;
    s_wr[0] = 0;
    s_wr[1] = 0;
  endtask

  task automatic req(int k, int ch, int op, logic [7:0] din, logic [7:0] mask);
    s_wr[k]   = 1;
    s_ch[k]   = ch;
    s_op[k]   = op;
    s_din[k]  = din;
    s_mask[k] = mask;
  endtask

  task automatic wait_idx(int k, int idx);
    for (int i = 0; i < 64 && m_idx[k] != idx; i++) tick();
  endtask

  task automatic wait_idle(int k, string nm);
    logic b;
    b = (k == 0) ? ba.busy : bb.busy;
    for (int i = 0; i < 80 && b; i++) begin
      tick();
      b = (k == 0) ? ba.busy : bb.busy;
    end
    chk(nm, 32'(b), 32'd0);
  endtask

  initial begin
    int bc;
    logic [2:0] pch;
    logic [1:0] pop;
    logic       pb;
    ids[0] = '{0, 1, 2, 4, 5, 6, 0, 0};
    ids[1] = '{0, 1, 2, 0, 0, 0, 0, 0};
    nch[0] = 6; nop[0] = 4;
    nch[1] = 3; nop[1] = 2;
    for (int k = 0; k < 2; k++) begin
      s_en[k] = 1; s_wr[k] = 0; s_ch[k] = 0; s_op[k] = 0;
      s_din[k] = 8'h00; s_mask[k] = 8'h00;
      m_tgt[k] = 0; m_din[k] = 8'h00; m_mask[k] = 8'h00;
    end
    rst = 1;
    tick();
    tick();
    rst = 0;
    chk("rst.zero", 32'(za), 32'd1);
    chk("rst.last", 32'(la), 32'd0);
    for (int i = 0; i < 26; i++) tick();

    wait_idx(0, 0);
    chk("a5.zero_at_req", 32'(za), 32'd1);
    req(0, 5, 2, 8'hA5, 8'hFF);
    tick();
    bc = 0;
    for (int i = 0; i < 40 && ba.busy; i++) begin
      bc++;
      tick();
    end
    chk("a5.busy_len", 32'(bc), 32'd16);
    chk("a5.done_pulse", 32'(ba.wr_done), 32'd1);
    tick();
    chk("a5.done_once", 32'(ba.wr_done), 32'd0);
    wait_idx(0, 16);
    chk("a5.cur_ch", 32'(cha), 32'd5);
    chk("a5.cur_op", 32'(opa), 32'd2);
    chk("a5.dout", 32'(da), 32'hA5);

    req(0, 0, 1, 8'hF0, 8'hFF);
    tick();
    wait_idle(0, "mask.preset_idle");
    req(0, 0, 1, 8'h0F, 8'h3C);
    tick();
    wait_idle(0, "mask.idle");
    wait_idx(0, 6);
    chk("mask.dout", 32'(da), 32'hCC);

    req(0, 3, 0, 8'h77, 8'hFF);
    tick();
    chk("inv_ch.err", 32'(ba.err), 32'd1);
    chk("inv_ch.busy", 32'(ba.busy), 32'd0);

    rst = 1;
    tick();
    rst = 0;
    wait_idx(0, 5);
    req(0, 1, 0, 8'h11, 8'hFF);
    tick();
    req(0, 2, 0, 8'h22, 8'hFF);
    tick();
    chk("dup.err", 32'(ba.err), 32'd1);
    chk("dup.busy", 32'(ba.busy), 32'd1);
    wait_idle(0, "dup.idle");
    wait_idx(0, 1);
    chk("dup.orig", 32'(da), 32'h11);
    wait_idx(0, 2);
    chk("dup.dropped", 32'(da), 32'h00);

    req(0, 6, 3, 8'h5A, 8'hFF);
    tick();
    tick();
    tick();
    chk("rstp.busy_before", 32'(ba.busy), 32'd1);
    rst = 1;
    tick();
    rst = 0;
    chk("rstp.busy", 32'(ba.busy), 32'd0);
    chk("rstp.err", 32'(ba.err), 32'd0);
    chk("rstp.cur_ch", 32'(cha), 32'd0);
    chk("rstp.cur_op", 32'(opa), 32'd0);
    for (int i = 0; i < 26; i++) tick();
    wait_idx(0, 23);
    chk("rstp.slot", 32'(da), 32'h00);

    req(1, 0, 3, 8'h33, 8'hFF);
    tick();
    chk("b.inv_op.err", 32'(bb.err), 32'd1);
    chk("b.inv_op.busy", 32'(bb.busy), 32'd0);
    wait_idx(1, 5);
    chk("b.last_ch", 32'(chb), 32'd2);
    chk("b.last_op", 32'(opb), 32'd1);
    chk("b.last", 32'(lb), 32'd1);
    tick();
    chk("b.wrap", 32'(zb), 32'd1);
    req(1, 2, 1, 8'h5A, 8'hF0);
    for (int i = 0; i < 24; i++) begin
      s_en[1] = (i % 2) == 1;
      pch = chb;
      pop = opb;
      pb  = bb.busy;
      tick();
      if (!s_en[1]) begin
        chk("b.hold_ch", 32'(chb), 32'(pch));
        chk("b.hold_op", 32'(opb), 32'(pop));
        if (i > 0) chk("b.hold_busy", 32'(bb.busy), 32'(pb));
      end
    end
    s_en[1] = 1;
    wait_idle(1, "b.idle");
    wait_idx(1, 5);
    chk("b.dout", 32'(db), 32'h50);

    tick();
    tick();
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
